// File: rtl/fft_capture_if.sv
// FFT capture bus: bin stream in, shared RAM write port out, peak report and
// hold/release handshake with the weightblock consumer.
interface fft_capture_if;
  logic        fft_valid;
  logic        fft_sop;
  logic        fft_eop;
  logic [27:0] fft1;
  logic [27:0] fft2;
  logic [27:0] fft3;
  logic [27:0] fft4;
  logic        wbdone;
  logic        wren;
  logic [9:0]  wraddress;
  logic [27:0] data1;
  logic [27:0] data2;
  logic [27:0] data3;
  logic [27:0] data4;
  logic        detectdone;
  logic [9:0]  maxbin;
  logic [14:0] maxmag;
  logic        frame_err;
  logic [7:0]  dropped;

  modport slave (
    input  fft_valid, fft_sop, fft_eop, fft1, fft2, fft3, fft4, wbdone,
    output wren, wraddress, data1, data2, data3, data4,
           detectdone, maxbin, maxmag, frame_err, dropped
  );

  modport master (
    output fft_valid, fft_sop, fft_eop, fft1, fft2, fft3, fft4, wbdone,
    input  wren, wraddress, data1, data2, data3, data4,
           detectdone, maxbin, maxmag, frame_err, dropped
  );
endinterface

// File: rtl/fft_capture.sv
// Captures one FFT frame per mic into shared RAMs, tracks the |re|+|im| peak of
// mic 1 over a bin window, reports it, then holds until the consumer is done.
module fft_capture #(
  parameter int NBINS  = 1024,
  parameter int BIN_LO = 1,
  parameter int BIN_HI = 511
) (
  input logic          clk,
  input logic          reset,
  fft_capture_if.slave bus
);
  localparam logic [9:0] LAST = 10'(NBINS - 1);
  localparam logic [9:0] LO   = 10'(BIN_LO);
  localparam logic [9:0] HI   = 10'(BIN_HI);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    REPORT  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Widened so that |-8192| is representable without saturation.
  function automatic logic [14:0] abs14(input logic [13:0] v);
    logic [13:0] neg;
    neg = ~v + 14'd1;
    return v[13] ? {1'b0, neg} : {1'b0, v};
  endfunction

  state_t      state_q, state_d;
  logic [9:0]  idx_q, idx_d;
  logic [9:0]  run_bin_q, run_bin_d;
  logic [14:0] run_max_q, run_max_d;
  logic        wren_q, wren_d;
  logic [9:0]  wraddress_q, wraddress_d;
  logic [27:0] data1_q, data1_d, data2_q, data2_d;
  logic [27:0] data3_q, data3_d, data4_q, data4_d;
  logic        detectdone_q, detectdone_d;
  logic [9:0]  maxbin_q, maxbin_d;
  logic [14:0] maxmag_q, maxmag_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  dropped_q, dropped_d;

  logic        accept;
  logic        start;
  logic        is_sop;
  logic        in_range;
  logic        single_bin_eop;
  logic [9:0]  wr_bin;
  logic [9:0]  base_bin;
  logic [14:0] base_max;
  logic [14:0] mag;

  assign mag            = abs14(bus.fft1[27:14]) + abs14(bus.fft1[13:0]);
  assign is_sop         = bus.fft_valid & bus.fft_sop;
  assign single_bin_eop = bus.fft_eop & (LAST == 10'd0);

  // Next-state, write-port, peak-tracking and report logic.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    run_bin_d    = run_bin_q;
    run_max_d    = run_max_q;
    wren_d       = 1'b0;
    wraddress_d  = wraddress_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    data3_d      = data3_q;
    data4_d      = data4_q;
    detectdone_d = 1'b0;
    maxbin_d     = maxbin_q;
    maxmag_d     = maxmag_q;
    frame_err_d  = 1'b0;
    dropped_d    = dropped_q;
    accept       = 1'b0;
    start        = 1'b0;
    wr_bin       = 10'd0;

    case (state_q)
      IDLE: begin
        if (is_sop) begin
          accept  = 1'b1;
          start   = 1'b1;
          state_d = single_bin_eop ? REPORT : CAPTURE;
        end else begin
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        if (is_sop) begin
          frame_err_d = 1'b1;
          accept      = 1'b1;
          start       = 1'b1;
          state_d     = single_bin_eop ? REPORT : CAPTURE;
        end else if (bus.fft_valid && (idx_q == LAST)) begin
          // Frame overran its last bin without eop: drop the extra sample.
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (bus.fft_valid) begin
          accept = 1'b1;
          wr_bin = idx_q + 10'd1;
          if (bus.fft_eop && (wr_bin == LAST)) begin
            state_d = REPORT;
          end else if (bus.fft_eop) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = CAPTURE;
          end
        end else begin
          state_d = CAPTURE;
        end
      end
      REPORT: begin
        detectdone_d = 1'b1;
        maxbin_d     = run_bin_q;
        maxmag_d     = run_max_q;
        state_d      = HOLD;
      end
      HOLD: begin
        if (is_sop && (dropped_q != 8'hFF)) begin
          dropped_d = dropped_q + 8'd1;
        end else begin
          dropped_d = dropped_q;
        end
        state_d = bus.wbdone ? IDLE : HOLD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    base_max = start ? 15'd0 : run_max_q;
    base_bin = start ? LO : run_bin_q;
    in_range = (wr_bin >= LO) && (wr_bin <= HI);

    if (accept) begin
      wren_d      = 1'b1;
      wraddress_d = wr_bin;
      data1_d     = bus.fft1;
      data2_d     = bus.fft2;
      data3_d     = bus.fft3;
      data4_d     = bus.fft4;
      idx_d       = wr_bin;
      if (in_range && (mag > base_max)) begin
        run_max_d = mag;
        run_bin_d = wr_bin;
      end else begin
        run_max_d = base_max;
        run_bin_d = base_bin;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= 10'd0;
      run_bin_q    <= 10'd0;
      run_max_q    <= 15'd0;
      wren_q       <= 1'b0;
      wraddress_q  <= 10'd0;
      data1_q      <= 28'd0;
      data2_q      <= 28'd0;
      data3_q      <= 28'd0;
      data4_q      <= 28'd0;
      detectdone_q <= 1'b0;
      maxbin_q     <= 10'd0;
      maxmag_q     <= 15'd0;
      frame_err_q  <= 1'b0;
      dropped_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      run_bin_q    <= run_bin_d;
      run_max_q    <= run_max_d;
      wren_q       <= wren_d;
      wraddress_q  <= wraddress_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      data3_q      <= data3_d;
      data4_q      <= data4_d;
      detectdone_q <= detectdone_d;
      maxbin_q     <= maxbin_d;
      maxmag_q     <= maxmag_d;
      frame_err_q  <= frame_err_d;
      dropped_q    <= dropped_d;
    end
  end

  assign bus.wren       = wren_q;
  assign bus.wraddress  = wraddress_q;
  assign bus.data1      = data1_q;
  assign bus.data2      = data2_q;
  assign bus.data3      = data3_q;
  assign bus.data4      = data4_q;
  assign bus.detectdone = detectdone_q;
  assign bus.maxbin     = maxbin_q;
  assign bus.maxmag     = maxmag_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.dropped    = dropped_q;
endmodule

// File: tb/tb_fft_capture.sv
// Randomized bench for fft_capture: frames drawn into arrays, peak and write
// trace predicted from the arrays, RAM writes and pulses collected by a monitor.
module tb_fft_capture;
  localparam int NBINS  = 1024;
  localparam int BIN_LO = 1;
  localparam int BIN_HI = 511;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_capture_if bus();

  fft_capture #(.NBINS(NBINS), .BIN_LO(BIN_LO), .BIN_HI(BIN_HI)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [27:0]  m1 [NBINS];
  logic [27:0]  m2 [NBINS];
  logic [27:0]  m3 [NBINS];
  logic [27:0]  m4 [NBINS];
  logic [9:0]   obs_addr [$];
  logic [111:0] obs_data [$];
  logic [9:0]   exp_addr [$];
  logic [111:0] exp_data [$];
  int det_count, det_cyc, err_count, eop_cyc;
  int last_bin, last_mag;

  // Collects RAM writes and output pulses mid-cycle.
  always @(negedge clk) begin
    if (bus.wren === 1'b1) begin
      obs_addr.push_back(bus.wraddress);
      obs_data.push_back({bus.data1, bus.data2, bus.data3, bus.data4});
    end
    if (bus.detectdone === 1'b1) begin
      det_count++;
      det_cyc = cyc;
    end
    if (bus.frame_err === 1'b1) err_count++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] pack(input int re, input int im);
    logic [13:0] r;
    logic [13:0] i;
    r = re[13:0];
    i = im[13:0];
    return {r, i};
  endfunction

  function automatic int mag_of(input logic [27:0] f);
    logic signed [13:0] re;
    logic signed [13:0] im;
    int r;
    int i;
    re = f[27:14];
    im = f[13:0];
    r = re;
    i = im;
    return (r < 0 ? -r : r) + (i < 0 ? -i : i);
  endfunction

  function automatic int srand(input int amp);
    return int'($urandom_range(0, 2 * amp)) - amp;
  endfunction

  task automatic ref_peak(output int bin, output int mag);
    mag = 0;
    bin = BIN_LO;
    for (int b = BIN_LO; b <= BIN_HI; b++) begin
      if (mag_of(m1[b]) > mag) begin
        mag = mag_of(m1[b]);
        bin = b;
      end
    end
  endtask

  task automatic fill_bg(input int amp);
    for (int b = 0; b < NBINS; b++) begin
      m1[b] = (amp == 0) ? 28'd0 : pack(srand(amp), srand(amp));
      m2[b] = 28'($urandom);
      m3[b] = 28'($urandom);
      m4[b] = 28'($urandom);
    end
  endtask

  task automatic clear_mon();
    obs_addr.delete();
    obs_data.delete();
    exp_addr.delete();
    exp_data.delete();
    det_count = 0;
    err_count = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic gap();
    bus.fft1 = 28'($urandom);
    bus.fft2 = 28'($urandom);
    if ($urandom_range(0, 7) == 0) idle(1);
  endtask

  task automatic put(input logic [27:0] a, input logic [27:0] b, input logic [27:0] c,
                     input logic [27:0] d, input logic sop, input logic eop);
    bus.fft_valid = 1'b1;
    bus.fft_sop   = sop;
    bus.fft_eop   = eop;
    bus.fft1      = a;
    bus.fft2      = b;
    bus.fft3      = c;
    bus.fft4      = d;
    @(posedge clk);
    #1;
    bus.fft_valid = 1'b0;
    bus.fft_sop   = 1'b0;
    bus.fft_eop   = 1'b0;
  endtask

  task automatic send(input int first, input int last, input bit with_sop,
                      input bit with_eop, input bit expect_wr);
    for (int b = first; b <= last; b++) begin
      gap();
      put(m1[b], m2[b], m3[b], m4[b], with_sop && (b == first), with_eop && (b == last));
      if (with_eop && (b == last)) eop_cyc = cyc;
      if (expect_wr) begin
        exp_addr.push_back(10'(b));
        exp_data.push_back({m1[b], m2[b], m3[b], m4[b]});
      end
    end
  endtask

  task automatic wait_det();
    for (int i = 0; i < 20 && det_count == 0; i++) @(negedge clk);
    idle(4);
  endtask

  task automatic check_writes(input string tag);
    int bad;
    bad = 0;
    check_eq({tag, "_wr_count"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) bad++;
    end
    check_eq({tag, "_wr_content"}, 32'(bad), 32'd0);
  endtask

  task automatic check_report(input string tag, input int errs);
    int eb;
    int em;
    ref_peak(eb, em);
    wait_det();
    check_eq({tag, "_det_count"}, 32'(det_count), 32'd1);
    check_eq({tag, "_det_latency"}, 32'(det_cyc - eop_cyc), 32'd1);
    check_eq({tag, "_frame_err"}, 32'(err_count), 32'(errs));
    check_eq({tag, "_maxbin"}, 32'(bus.maxbin), 32'(eb));
    check_eq({tag, "_maxmag"}, 32'(bus.maxmag), 32'(em));
    check_writes(tag);
    last_bin = eb;
    last_mag = em;
  endtask

  task automatic run_good(input string tag);
    clear_mon();
    send(0, NBINS - 1, 1'b1, 1'b1, 1'b1);
    check_report(tag, 0);
  endtask

  task automatic release_hold();
    bus.wbdone = 1'b1;
    idle(1);
    bus.wbdone = 1'b0;
    idle(2);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_wren"}, 32'(bus.wren), 32'd0);
    check_eq({tag, "_wraddress"}, 32'(bus.wraddress), 32'd0);
    check_eq({tag, "_data1"}, 32'(bus.data1), 32'd0);
    check_eq({tag, "_data2"}, 32'(bus.data2), 32'd0);
    check_eq({tag, "_data3"}, 32'(bus.data3), 32'd0);
    check_eq({tag, "_data4"}, 32'(bus.data4), 32'd0);
    check_eq({tag, "_detectdone"}, 32'(bus.detectdone), 32'd0);
    check_eq({tag, "_maxbin"}, 32'(bus.maxbin), 32'd0);
    check_eq({tag, "_maxmag"}, 32'(bus.maxmag), 32'd0);
    check_eq({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
    check_eq({tag, "_dropped"}, 32'(bus.dropped), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    bus.fft_valid = 1'b0;
    bus.fft_sop   = 1'b0;
    bus.fft_eop   = 1'b0;
    bus.fft1      = 28'd0;
    bus.fft2      = 28'd0;
    bus.fft3      = 28'd0;
    bus.fft4      = 28'd0;
    bus.wbdone    = 1'b0;
    reset         = 1'b1;
    #2;
    reset = 1'b0;
    idle(3);
    check_zero("reset");
    reset = 1'b1;
    idle(2);

    // Valid without sop while idle must not write.
    clear_mon();
    fill_bg(20);
    send(3, 8, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_writes("idle_nosop");

    fill_bg(0);
    m1[44] = pack(-226, -310);
    run_good("bin44");
    check_eq("bin44_const_bin", 32'(bus.maxbin), 32'd44);
    check_eq("bin44_const_mag", 32'(bus.maxmag), 32'd536);
    release_hold();

    m1[100] = pack(-226, -310);
    run_good("tie44_100");
    check_eq("tie_const_bin", 32'(bus.maxbin), 32'd44);
    release_hold();

    fill_bg(0);
    m1[600] = pack(8000, 1000);
    m1[10]  = pack(50, -50);
    run_good("window");
    check_eq("window_const_bin", 32'(bus.maxbin), 32'd10);
    check_eq("window_const_mag", 32'(bus.maxmag), 32'd100);
    release_hold();

    fill_bg(0);
    m1[0]   = pack(8191, 8191);
    m1[512] = pack(8191, 8191);
    m1[511] = pack(-8192, -8192);
    run_good("edges");
    check_eq("edges_const_mag", 32'(bus.maxmag), 32'd16384);
    release_hold();

    for (int k = 0; k < 3; k++) begin
      fill_bg((k == 0) ? 8191 : 20);
      run_good($sformatf("rand%0d", k));
      release_hold();
    end

    clear_mon();
    fill_bg(20);
    send(0, 500, 1'b1, 1'b1, 1'b1);
    idle(6);
    check_eq("early_eop_err", 32'(err_count), 32'd1);
    check_eq("early_eop_det", 32'(det_count), 32'd0);
    check_eq("early_eop_maxbin", 32'(bus.maxbin), 32'(last_bin));
    check_eq("early_eop_maxmag", 32'(bus.maxmag), 32'(last_mag));
    check_writes("early_eop");

    fill_bg(20);
    run_good("pre_hold");
    clear_mon();
    for (int k = 0; k < 2; k++) begin
      fill_bg(20);
      send(0, NBINS - 1, 1'b1, 1'b1, 1'b0);
    end
    idle(4);
    check_writes("hold");
    check_eq("hold_det", 32'(det_count), 32'd0);
    check_eq("hold_dropped", 32'(bus.dropped), 32'd2);
    release_hold();
    fill_bg(20);
    run_good("post_hold");
    release_hold();

    // Restart via sop mid-frame; the big peak in the abandoned part must not survive.
    clear_mon();
    fill_bg(20);
    m1[150] = pack(5000, 5000);
    send(0, 200, 1'b1, 1'b0, 1'b1);
    fill_bg(20);
    send(0, NBINS - 1, 1'b1, 1'b1, 1'b1);
    check_report("sop_restart", 1);
    release_hold();

    clear_mon();
    fill_bg(20);
    send(0, NBINS - 1, 1'b1, 1'b0, 1'b1);
    gap();
    put(m1[5], m2[5], m3[5], m4[5], 1'b0, 1'b0);
    idle(4);
    check_eq("overrun_err", 32'(err_count), 32'd1);
    check_eq("overrun_det", 32'(det_count), 32'd0);
    check_writes("overrun");
    fill_bg(20);
    run_good("after_overrun");
    release_hold();

    clear_mon();
    fill_bg(20);
    send(0, 299, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_zero("mid_reset");
    idle(2);
    reset = 1'b1;
    idle(2);
    fill_bg(20);
    m1[300] = pack(-1000, 700);
    run_good("after_reset");

    clear_mon();
    for (int k = 0; k < 254; k++) put(28'($urandom), 28'd0, 28'd0, 28'd0, 1'b1, 1'b0);
    idle(1);
    check_eq("dropped_254", 32'(bus.dropped), 32'd254);
    for (int k = 0; k < 40; k++) put(28'($urandom), 28'd0, 28'd0, 28'd0, 1'b1, 1'b0);
    idle(1);
    check_eq("dropped_sat", 32'(bus.dropped), 32'd255);
    check_writes("sat_hold");
    release_hold();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fft_capture.md
FFT_CAPTURE -- requirements
Module: fft_capture

Interface
REQ-001 Parameter NBINS, 1024: bins per FFT frame; RAM depth.
REQ-002 Parameter BIN_LO, 1: lowest bin eligible for peak search.
REQ-003 Parameter BIN_HI, 511: highest bin eligible for peak search.
REQ-004 Port clk  in  1: single clock; all logic on rising edge.
REQ-005 Port reset  in  1: asynchronous, active-low reset.
REQ-006 Port fft_valid  in  1: input sample valid this cycle.
REQ-007 Port fft_sop  in  1: first bin of frame, qualified by fft_valid.
REQ-008 Port fft_eop  in  1: last bin of frame, qualified by fft_valid.
REQ-009 Ports fft1..fft4  in  28 each: per-mic bin sample, {re[27:14], im[13:0]}, two's complement.
REQ-010 Port wbdone  in  1: consumer (weightblock) finished reading RAMs; level or pulse.
REQ-011 Port wren  out  1: shared write enable for the four FFT RAMs.
REQ-012 Port wraddress  out  10: shared RAM write address (bin index).
REQ-013 Ports data1..data4  out  28 each: RAM write data, unmodified copy of fft1..fft4.
REQ-014 Port detectdone  out  1: one-cycle pulse; frame stored and peak found.
REQ-015 Port maxbin  out  10: bin index of peak; feeds weightblock maxbin.
REQ-016 Port maxmag  out  15: peak magnitude.
REQ-017 Port frame_err  out  1: one-cycle pulse on malformed frame.
REQ-018 Port dropped  out  8: saturating count of frames discarded while held.

Function
REQ-019 FSM states IDLE, CAPTURE, REPORT, HOLD.
REQ-020 IDLE: valid&sop -> write bin 0, go CAPTURE; valid without sop ignored, no write.
REQ-021 CAPTURE: each valid sample written at next sequential bin index; invalid cycles write nothing, index held.
REQ-022 Write path registered: sample accepted at edge k -> wren=1, wraddress, data1..4 presented in cycle k+1 only.
REQ-023 Magnitude = |re|+|im| of fft1, 15-bit unsigned; |-8192| = 8192, no saturation needed.
REQ-024 Peak search only over bins BIN_LO..BIN_HI; running max cleared to 0 and candidate bin set to BIN_LO at sop.
REQ-025 Update candidate only when magnitude strictly greater; ties keep lowest bin.
REQ-026 valid&eop at index NBINS-1 -> REPORT; detectdone=1 in cycle k+2 (one cycle after final wren), exactly one cycle.
REQ-027 maxbin/maxmag registered in the same cycle detectdone rises; held stable until next REPORT.
REQ-028 REPORT -> HOLD unconditionally after one cycle.
REQ-029 HOLD: no RAM writes; wbdone=1 -> IDLE next cycle; wbdone ignored in all other states.
REQ-030 HOLD: each valid&sop increments dropped (saturates at 255); whole frame discarded.
REQ-031 eop at index != NBINS-1 -> frame_err pulse, IDLE, no detectdone, maxbin/maxmag unchanged.
REQ-032 Index reaches NBINS-1 without eop, next valid sample -> frame_err, IDLE, that sample not written.
REQ-033 sop during CAPTURE -> frame_err pulse, restart: sample written at bin 0, peak search reset.
REQ-034 sop and eop together on one valid sample -> treated as sop; eop ignored unless NBINS=1.

Reset
REQ-035 reset=0 asynchronously forces IDLE; wren, wraddress, data1..4, detectdone, maxbin, maxmag, frame_err, dropped all 0.
REQ-036 Reset mid-frame discards partial frame; first valid&sop after release writes bin 0.

Verification
REQ-037 Full frame, bin 44 fft1={-226,-310}, all other bins fft1=0 -> wraddress 0..1023 once each, maxbin=44, maxmag=536, detectdone 2 cycles after eop edge.
REQ-038 Bins 44 and 100 both {-226,-310} -> maxbin=44, maxmag=536.
REQ-039 Bin 600 = {8000,1000}, bin 10 = {50,-50}, rest 0 -> maxbin=10, maxmag=100.
REQ-040 eop at bin 500 -> frame_err single pulse, no detectdone, maxbin unchanged from prior frame.
REQ-041 After detectdone, two frames sent, wbdone withheld -> wren stays 0, dropped=2; wbdone pulse then frame -> captured normally.
REQ-042 reset=0 at bin 300 with valid gaps in stream -> all outputs 0 immediately; next frame starts at address 0, correct maxbin.
